// File: rtl/rr_arb4_sel_pkg.sv
// Shared types and constants for the 4-source round-robin select arbiter.
package rr_arb4_sel_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  localparam int IDX_W   = 2;
  localparam int NUM_SRC = 4;

endpackage

// File: rtl/rr_arb4_sel_pick4.sv
// Combinational round-robin search: first set request at start_i, start_i+1, ... (mod 4).
module rr_pick4
  import rr_arb4_sel_pkg::*;
(
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IDX_W-1:0]   start_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               found_o
);

  logic [IDX_W-1:0] cand;

  // Walk the order backwards so the earliest position in the search order wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = start_i;
    cand    = start_i;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      cand = start_i + IDX_W'(k);
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arb4_sel.sv
// Round-robin arbiter driving a 4:1 mux select, with burst lock and a one-entry
// valid/ready output register. Define RR4_PARITY_EN to add the OUT_PAR output.
//
// Output handshake: a beat transfers on any cycle where OUT_VALID and OUT_READY
// are both high; OUT_DATA/OUT_SRC never change while OUT_VALID is high and
// OUT_READY is low, and a new grant may load in the same cycle the old beat drains.
module rr_arb4_sel
  import rr_arb4_sel_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] REQ,
  input  logic [WIDTH-1:0]   F_IN,
  input  logic               OUT_READY,
  output logic [IDX_W-1:0]   S,
  output logic [NUM_SRC-1:0] GNT,
  output logic [WIDTH-1:0]   OUT_DATA,
  output logic [IDX_W-1:0]   OUT_SRC,
  output logic               OUT_VALID,
`ifdef RR4_PARITY_EN
  output logic               OUT_PAR,
`endif
  output state_e             dbg_state_o
);

  localparam logic [3:0] BURST_CNT = 4'(BURST_LEN);
  localparam state_e     AFTER_GRANT = (BURST_LEN > 1) ? LOCK : IDLE;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] data_q;
  logic [IDX_W-1:0] src_q;
  logic             valid_q;

  logic             can_load;
  logic             grant;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;

  rr_pick4 u_pick (
    .req_i   (REQ),
    .start_i (ptr_q + 2'd1),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign can_load = !valid_q | OUT_READY;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant   = 1'b0;
    win     = ptr_q;
    case (state_q)
      IDLE: begin
        if (can_load && pick_found) begin
          grant   = 1'b1;
          win     = pick_idx;
          ptr_d   = pick_idx;
          cnt_d   = 4'd1;
          state_d = AFTER_GRANT;
        end
      end
      LOCK: begin
        if (can_load && REQ[ptr_q]) begin
          grant = 1'b1;
          win   = ptr_q;
          if (cnt_q + 4'd1 == BURST_CNT) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else if (can_load) begin
          // Owner dropped its request: release and re-arbitrate in this cycle.
          if (pick_found) begin
            grant   = 1'b1;
            win     = pick_idx;
            ptr_d   = pick_idx;
            cnt_d   = 4'd1;
            state_d = AFTER_GRANT;
          end else begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      grant = 1'b0;
    end
  end

  // Idle select parks on PTR so the mux does not toggle between grants.
  assign S   = grant ? win : ptr_q;
  assign GNT = grant ? (4'b0001 << win) : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ptr_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
    end else if (grant) begin
      valid_q <= 1'b1;
      data_q  <= F_IN;
      src_q   <= win;
    end else if (OUT_READY) begin
      valid_q <= 1'b0;
    end
  end

`ifdef RR4_PARITY_EN
  logic par_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (grant) begin
      par_q <= ^F_IN;
    end
  end
  assign OUT_PAR = par_q;
`endif

  assign OUT_DATA    = data_q;
  assign OUT_SRC     = src_q;
  assign OUT_VALID   = valid_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rr_arb4_sel.sv
// Directed bench for rr_arb4_sel: one instance with BURST_LEN=1, one with BURST_LEN=4.
module tb_rr_arb4_sel;
  import rr_arb4_sel_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [7:0] f_in;
  logic       out_ready;

  logic [1:0] s1, s4;
  logic [3:0] gnt1, gnt4;
  logic [7:0] data1, data4;
  logic [1:0] src1, src4;
  logic       valid1, valid4;
  state_e     st1, st4;
`ifdef RR4_PARITY_EN
  logic       par1, par4;
`endif

  int checks;
  int errors;

  rr_arb4_sel #(.WIDTH(8), .BURST_LEN(1)) u_dut1 (
    .clk (clk), .rst (rst), .REQ (req), .F_IN (f_in), .OUT_READY (out_ready),
    .S (s1), .GNT (gnt1), .OUT_DATA (data1), .OUT_SRC (src1), .OUT_VALID (valid1),
`ifdef RR4_PARITY_EN
    .OUT_PAR (par1),
`endif
    .dbg_state_o (st1)
  );

  rr_arb4_sel #(.WIDTH(8), .BURST_LEN(4)) u_dut4 (
    .clk (clk), .rst (rst), .REQ (req), .F_IN (f_in), .OUT_READY (out_ready),
    .S (s4), .GNT (gnt4), .OUT_DATA (data4), .OUT_SRC (src4), .OUT_VALID (valid4),
`ifdef RR4_PARITY_EN
    .OUT_PAR (par4),
`endif
    .dbg_state_o (st4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two reset cycles; returns at a negedge with rst just released.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = 4'b0000; out_ready = 1'b1; f_in = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req = 4'b0000; out_ready = 1'b1; f_in = 8'h00;
    @(negedge clk);
    req = 4'b1111;
    #1;
    checks++;
    if (gnt4 !== 4'b0000 || gnt1 !== 4'b0000) begin
      errors++; $display("FAIL reset_gnt got %b/%b exp 0000", gnt1, gnt4);
    end
    checks++;
    if (s4 !== 2'd3) begin
      errors++; $display("FAIL reset_s got %0d exp 3", s4);
    end
    @(negedge clk);
    rst = 1'b0; req = 4'b0000;
    #1;
    checks++;
    if (valid4 !== 1'b0 || data4 !== 8'h00 || src4 !== 2'd0 || st4 !== IDLE) begin
      errors++;
      $display("FAIL reset_out got v=%b d=%h s=%0d st=%0d exp 0/00/0/IDLE", valid4, data4, src4, st4);
    end
  endtask

  task automatic test_rr_burst1();
    logic [3:0] exp_g;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      req = 4'b1111; out_ready = 1'b1; f_in = 8'h10 + 8'(k);
      exp_g = 4'b0001 << (k % 4);
      #1;
      checks++;
      if (gnt1 !== exp_g || s1 !== 2'(k % 4)) begin
        errors++; $display("FAIL rr1_gnt[%0d] got %b s=%0d exp %b s=%0d", k, gnt1, s1, exp_g, k % 4);
      end
      if (k > 0) begin
        checks++;
        if (valid1 !== 1'b1 || src1 !== 2'((k - 1) % 4) || data1 !== 8'h10 + 8'(k - 1)) begin
          errors++;
          $display("FAIL rr1_out[%0d] got v=%b src=%0d d=%h exp 1/%0d/%h", k, valid1, src1, data1, (k - 1) % 4, 8'h10 + 8'(k - 1));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_burst4();
    logic [3:0] exp_g;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      req = 4'b0101; out_ready = 1'b1;
      exp_g = ((k / 4) % 2 == 0) ? 4'b0001 : 4'b0100;
      #1;
      checks++;
      if (gnt4 !== exp_g) begin
        errors++; $display("FAIL burst4_gnt[%0d] got %b exp %b", k, gnt4, exp_g);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_release();
    do_reset();
    req = 4'b0010; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (st4 !== LOCK || src4 !== 2'd1) begin
      errors++; $display("FAIL release_lock got st=%0d src=%0d exp LOCK/1", st4, src4);
    end
    req = 4'b1001;
    #1;
    checks++;
    if (gnt4 !== 4'b1000 || s4 !== 2'd3) begin
      errors++; $display("FAIL release_gnt got %b s=%0d exp 1000 s=3", gnt4, s4);
    end
    @(negedge clk);
    checks++;
    if (src4 !== 2'd3 || valid4 !== 1'b1) begin
      errors++; $display("FAIL release_out got src=%0d v=%b exp 3/1", src4, valid4);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 4'b0001; f_in = 8'hA5; out_ready = 1'b1;
    @(negedge clk);
    req = 4'b0010; f_in = 8'h5A; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (gnt4 !== 4'b0000 || data4 !== 8'hA5 || valid4 !== 1'b1 || src4 !== 2'd0 || s4 !== 2'd0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got g=%b d=%h v=%b src=%0d s=%0d exp 0000/a5/1/0/0", k, gnt4, data4, valid4, src4, s4);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (gnt4 !== 4'b0010 || s4 !== 2'd1) begin
      errors++; $display("FAIL bp_release got %b s=%0d exp 0010 s=1", gnt4, s4);
    end
    @(negedge clk);
    req = 4'b0000;
    #1;
    checks++;
    if (data4 !== 8'h5A || src4 !== 2'd1 || valid4 !== 1'b1) begin
      errors++; $display("FAIL bp_newdata got d=%h src=%0d v=%b exp 5a/1/1", data4, src4, valid4);
    end
    @(negedge clk);
    checks++;
    if (valid4 !== 1'b0) begin
      errors++; $display("FAIL bp_drain got v=%b exp 0", valid4);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0100; out_ready = 1'b1; f_in = 8'h33;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; req = 4'b1111;
    #1;
    checks++;
    if (st4 !== LOCK || gnt4 !== 4'b0000) begin
      errors++; $display("FAIL midrst_in got st=%0d g=%b exp LOCK/0000", st4, gnt4);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (valid4 !== 1'b0 || st4 !== IDLE || gnt4 !== 4'b0001) begin
      errors++; $display("FAIL midrst_after got v=%b st=%0d g=%b exp 0/IDLE/0001", valid4, st4, gnt4);
    end
    @(negedge clk);
  endtask

`ifdef RR4_PARITY_EN
  task automatic test_parity();
    do_reset();
    #1;
    checks++;
    if (par4 !== 1'b0) begin
      errors++; $display("FAIL par_reset got %b exp 0", par4);
    end
    req = 4'b0001; out_ready = 1'b1; f_in = 8'h07;
    @(negedge clk);
    checks++;
    if (par4 !== 1'b1) begin
      errors++; $display("FAIL par_07 got %b exp 1", par4);
    end
    f_in = 8'h03;
    @(negedge clk);
    checks++;
    if (par4 !== 1'b0) begin
      errors++; $display("FAIL par_03 got %b exp 0", par4);
    end
  endtask
`endif

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; req = 4'b0000; f_in = 8'h00; out_ready = 1'b1;
    test_reset();
    test_rr_burst1();
    test_burst4();
    test_release();
    test_backpressure();
    test_reset_mid();
`ifdef RR4_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arb4_sel.md
Name: rr_arb4_sel

Overview:
- Round-robin arbiter and output register that drives the select of the 8-bit 4:1 mux and consumes its F output.
- Four sources raise REQ. The block picks one winner per free output slot and drives S to the mux. It pulses GNT to the winner and registers the muxed byte into a single-entry valid/ready output stage.
- A burst lock keeps one source granted for up to BURST_LEN consecutive beats.

Parameters:
- WIDTH, 8, data width of F_IN/OUT_DATA (matches mux width).
- BURST_LEN, 4, max consecutive grants to one owner; legal 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- REQ  input  4  per-source request; bit i = source i (mux input A,B,C,D = 0..3).
- F_IN  input  WIDTH  muxed data returned from the 4:1 mux F output.
- OUT_READY  input  1  downstream accepts OUT_DATA this cycle.
- S  output  2  mux select, combinational.
- GNT  output  4  one-hot grant, combinational; source i's data consumed this cycle.
- OUT_DATA  output  WIDTH  registered byte.
- OUT_SRC  output  2  index of the source that produced OUT_DATA.
- OUT_VALID  output  1  OUT_DATA/OUT_SRC valid.

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous, active-high.
- Reset values:
  - PTR=3, so the first search starts at source 0.
  - State=IDLE, CNT=0.
  - OUT_VALID=0, OUT_DATA=0, OUT_SRC=0.
  - While rst is high, GNT=0 and S=PTR.
- Slot free: can_load = !OUT_VALID | OUT_READY.
- RR search: order PTR+1, PTR+2, PTR+3, PTR (mod 4). The first set REQ bit is the winner W.
- State IDLE:
  - If can_load & |REQ: grant W; PTR<=W; CNT<=1.
  - Go to LOCK if BURST_LEN>1, else stay in IDLE.
- State LOCK (owner=PTR):
  - can_load & REQ[PTR]: grant PTR; CNT<=CNT+1. When CNT+1==BURST_LEN, go to IDLE and CNT<=0.
  - can_load & !REQ[PTR]: release the lock. Perform the IDLE RR search in the same cycle, starting at PTR+1. If no REQ, go to IDLE with no grant.
  - !can_load: hold state, CNT and PTR; no grant.
- Grant cycle:
  - GNT[W]=1 (exactly one bit) and S=W.
  - On the edge: OUT_DATA<=F_IN, OUT_SRC<=W, OUT_VALID<=1.
- No-grant cycle:
  - GNT=0 and S=PTR (stable, avoids mux glitching).
  - OUT_VALID<=0 if OUT_READY, else hold.
- Latency: one cycle from grant to OUT_VALID. Full throughput (one beat per cycle) when OUT_READY is held high.
- Simultaneous drain+load (OUT_VALID & OUT_READY & grant): the new byte replaces the old one and OUT_VALID stays 1.
- Back-pressure: OUT_DATA/OUT_SRC are stable while OUT_VALID & !OUT_READY.
- A REQ bit dropping without a grant is legal; it is not latched.
- After a burst ends at BURST_LEN, the next search starts at owner+1. The owner is not re-granted while any other REQ is set. A sole requester may be re-granted immediately.
- Reset mid-burst: lock dropped and output entry discarded; the next grant search starts at source 0.

Optional Feature:
- RR4_PARITY_EN defined: adds output port OUT_PAR (1 bit).
  - OUT_PAR = even parity (XOR) of F_IN, registered with OUT_DATA.
  - Reset value 0; held under back-pressure.
- RR4_PARITY_EN undefined: no OUT_PAR port and no parity logic.

Decomposition:
- Shared package:
  - State encoding (IDLE=1'b0, LOCK=1'b1).
  - Source index width constant (2).
  - Constant NUM_SRC=4.
- One natural sub-module: rr_pick4. This is the combinational search: inputs REQ and start index; outputs winner index and found flag. It is reusable by other arbiters.

Test Plan:
- Reset then REQ=4'b1111, OUT_READY=1, BURST_LEN=1 -> GNT cycles 0001,0010,0100,1000,0001; OUT_SRC follows 0,1,2,3 one cycle later; OUT_VALID=1 continuously.
- BURST_LEN=4, REQ=4'b0101 held, OUT_READY=1 -> source 0 granted 4 beats, then source 2 granted 4 beats, then source 0 again.
- Burst release: source 1 locked with CNT=2, then REQ[1] drops while REQ=4'b1001 -> same-cycle grant to source 3, S=3.
- Back-pressure: grant with F_IN=8'hA5, then OUT_READY=0 for 3 cycles with REQ=4'b0010 -> OUT_DATA stays 8'hA5 and GNT=0. GNT[1] fires in the cycle OUT_READY rises.
- Reset mid-burst: rst for 1 cycle in LOCK -> OUT_VALID=0 next cycle; with REQ=4'b1111 the next grant is source 0.
- With RR4_PARITY_EN: F_IN=8'h07 granted -> OUT_PAR=1; F_IN=8'h03 -> OUT_PAR=0.
